servo_pwm_guante: RTL and testbench
===================================

# servo_pwm_guante

Converts the two 15-bit ADC channel readings (`gripper`, `base`) from the glove's I2C ADC reader into two 50 Hz hobby-servo PWM outputs for the arm. Each channel is linearly mapped to a 1.0–2.0 ms pulse and slew-limited once per 20 ms frame. Updates freeze while the reader is paused. The block sits directly downstream of the ADC reader and drives the servo pins.

## Interface
- `FRAME_CYCLES`, 1_000_000: PWM period in `clk` cycles (20 ms at 50 MHz).
- `MIN_PULSE`, 50_000: pulse width in cycles for input 0 (1.0 ms).
- `SPAN`, 50_000: added width at full-scale input (to 2.0 ms).
- `MAX_STEP`, 2_500: maximum width change per frame, in cycles.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  **one clock; reset is synchronous and active-high**.
- `gripper`  in  15  unsigned ADC reading, gripper channel.
- `base`  in  15  unsigned ADC reading, base channel.
- `pausar_lectura`  in  1  high = hold both servo widths.
- `pwm_gripper`  out  1  servo pulse, gripper.
- `pwm_base`  out  1  servo pulse, base.
- `frame`  out  1  one-cycle strobe on the last cycle of each frame.

## Operation
- Frame counter `cnt` is 20 bits and runs 0..FRAME_CYCLES-1, then wraps to 0.
- Target per channel, computed every cycle and registered with 1-cycle latency: `target = MIN_PULSE + ((x * SPAN) >> 15)`.
  - Product is 31 bits unsigned, truncated on shift. Target is 17 bits.
  - Input 0 gives 50_000; input 32767 gives 99_998.
- Width register `w` (17 bits) updates only when `cnt == FRAME_CYCLES-1`:
  - If `pausar_lectura` is high: `w` unchanged.
  - Else if `target > w + MAX_STEP`: `w += MAX_STEP`.
  - Else if `target + MAX_STEP < w`: `w -= MAX_STEP`.
  - Else: `w = target`.
- PWM output, registered: `pwm <= (cnt < w)`.
  - `w` is never 0 and never ≥ FRAME_CYCLES, so the output is never stuck.
- Both channels share `cnt` and update on the same cycle; they are independent otherwise.
- Input changes mid-frame affect only the target; the pulse in progress is never altered.

## Timing
- Reset values:
  - `cnt` = 0.
  - `w` = MIN_PULSE + SPAN/2 = 75_000 on both channels.
  - `pwm_gripper`, `pwm_base`, `frame` = 0.
  - Target registers = 75_000.
- First cycle after reset deasserts: `pwm` goes high one cycle later and stays high for exactly `w` cycles per frame.
- `frame` is high for one cycle when `cnt == FRAME_CYCLES-1`. That is the same edge on which `w` updates.
- A new `w` takes effect from the next frame's first pulse cycle.
- Input-to-pulse latency: the input must be stable at least 2 cycles before the frame end to be used.
- `rst` asserted mid-frame: on the next edge `cnt`, `w` and the outputs return to their reset values. The partial pulse is truncated.
- Simultaneous pause and frame end: the pause wins and `w` holds.
- Pause release: the next frame end resumes normal slewing from the held `w`.

## Structure
- Shared package `guante_pkg` holds the frame, pulse and step constants and the 17-bit width type.
- Sub-module `servo_channel` (mapping, target register, slew logic, PWM compare) is instantiated twice.
- The top level owns `cnt` and `frame` and broadcasts them to both channels.

## Test plan
- **Reset, inputs 16384:** each output is high 75_000 cycles per 1_000_000-cycle period.
- **`gripper` = 32767 held:** gripper widths step 77_500, 80_000, …, 97_500, then 99_998 at the 10th frame. `base` width is unchanged.
- **`base` = 0 from center:** base width falls by 2_500 per frame and reaches 50_000 after 10 frames. It never goes below 50_000.
- **`base` 16384 → 16500 mid-frame:** current pulse stays 75_000; next frame is 75_177.
- **`pausar_lectura` high during a ramp:** width frozen for all paused frames. After release, the ramp resumes from the frozen value.
- **`rst` at cnt = 40_000 mid-ramp:** outputs drop to 0 on the next edge. Widths return to 75_000. `frame` first fires 1_000_000 cycles after reset release.

Source files
------------

// File: rtl/guante_pkg.sv
// Shared constants and types for the glove-to-servo PWM block.
package guante_pkg;

    localparam int unsigned FRAME_CYCLES_DFLT = 1_000_000;
    localparam int unsigned MIN_PULSE_DFLT    = 50_000;
    localparam int unsigned SPAN_DFLT         = 50_000;
    localparam int unsigned MAX_STEP_DFLT     = 2_500;
    localparam int unsigned CNT_W             = 20;
    localparam int unsigned ADC_W             = 15;

    typedef logic [16:0]      width_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [ADC_W-1:0] adc_t;

    // MIN + ((x * SPAN) >> 15); the product stays within 31 bits for 15-bit inputs.
    function automatic width_t map_target(adc_t x, int unsigned min_p, int unsigned span);
        logic [31:0] prod;
        prod = 32'(x) * span;
        return width_t'(min_p + (prod >> ADC_W));
    endfunction

endpackage

// File: rtl/servo_pwm_guante_if.sv
// ADC-side inputs and servo-side outputs of the PWM block.
interface servo_pwm_guante_if
    import guante_pkg::*;
;
    adc_t gripper;
    adc_t base;
    logic pausar_lectura;
    logic pwm_gripper;
    logic pwm_base;
    logic frame;

    modport master (
        output gripper, base, pausar_lectura,
        input  pwm_gripper, pwm_base, frame
    );

    modport slave (
        input  gripper, base, pausar_lectura,
        output pwm_gripper, pwm_base, frame
    );
endinterface

// File: rtl/servo_channel.sv
// One servo channel: input mapping, target register, per-frame slew limit, PWM compare.
module servo_channel
    import guante_pkg::*;
#(
    parameter int unsigned MIN_P  = MIN_PULSE_DFLT,
    parameter int unsigned SPAN_P = SPAN_DFLT,
    parameter int unsigned STEP_P = MAX_STEP_DFLT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  adc_t x_i,
    input  logic pause_i,
    input  cnt_t cnt_i,
    input  logic last_i,
    output logic pwm_o
);
    localparam width_t CENTER = width_t'(MIN_P + SPAN_P / 2);
    localparam width_t STEP   = width_t'(STEP_P);

    width_t tgt_q, tgt_d;
    width_t w_q, w_d;
    logic   pwm_q, pwm_d;

    always_comb begin
        tgt_d = map_target(x_i, MIN_P, SPAN_P);
        w_d   = w_q;
        // Width only moves on the last cycle of a frame, so a pulse in flight is never reshaped.
        if (last_i && !pause_i) begin
            if (tgt_q > w_q + STEP) begin
                w_d = w_q + STEP;
            end else if (tgt_q + STEP < w_q) begin
                w_d = w_q - STEP;
            end else begin
                w_d = tgt_q;
            end
        end
        pwm_d = (cnt_i < cnt_t'(w_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_q <= CENTER;
            w_q   <= CENTER;
            pwm_q <= 1'b0;
        end else begin
            tgt_q <= tgt_d;
            w_q   <= w_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/servo_pwm_guante.sv
// Two-channel 50 Hz hobby-servo PWM driver fed by the glove ADC reader.
module servo_pwm_guante
    import guante_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DFLT,
    parameter int unsigned MIN_PULSE    = MIN_PULSE_DFLT,
    parameter int unsigned SPAN         = SPAN_DFLT,
    parameter int unsigned MAX_STEP     = MAX_STEP_DFLT
) (
    input logic clk,
    input logic rst,
    servo_pwm_guante_if.slave bus
);
    localparam cnt_t LAST = cnt_t'(FRAME_CYCLES - 1);

    cnt_t cnt_q, cnt_d;
    logic frame_q;
    logic last_cycle;

    assign last_cycle = (cnt_q == LAST);

    always_comb begin
        cnt_d = last_cycle ? '0 : cnt_q + cnt_t'(1);
    end

    // frame is registered from the next count so it is high while cnt sits at LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= (cnt_d == LAST);
        end
    end

    assign bus.frame = frame_q;

    servo_channel #(
        .MIN_P  (MIN_PULSE),
        .SPAN_P (SPAN),
        .STEP_P (MAX_STEP)
    ) u_gripper (
        .clk_i   (clk),
        .rst_i   (rst),
        .x_i     (bus.gripper),
        .pause_i (bus.pausar_lectura),
        .cnt_i   (cnt_q),
        .last_i  (last_cycle),
        .pwm_o   (bus.pwm_gripper)
    );

    servo_channel #(
        .MIN_P  (MIN_PULSE),
        .SPAN_P (SPAN),
        .STEP_P (MAX_STEP)
    ) u_base (
        .clk_i   (clk),
        .rst_i   (rst),
        .x_i     (bus.base),
        .pause_i (bus.pausar_lectura),
        .cnt_i   (cnt_q),
        .last_i  (last_cycle),
        .pwm_o   (bus.pwm_base)
    );
endmodule

// File: tb/tb_servo_pwm_guante.sv
// Frame-level bench: measured pulse widths per frame against a queued reference model.
module tb_servo_pwm_guante;
    localparam int F    = 1600;
    localparam int MINP = 500;
    localparam int SPN  = 1000;
    localparam int STP  = 50;
    localparam int CTR  = MINP + SPN / 2;

    typedef struct {
        int g;
        int b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    servo_pwm_guante_if bus ();

    servo_pwm_guante #(
        .FRAME_CYCLES (F),
        .MIN_PULSE    (MINP),
        .SPAN         (SPN),
        .MAX_STEP     (STP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests;
    int   fails;
    int   mg, mb;
    exp_t q[$];

    function automatic int tgt(int x);
        return MINP + (x * SPN) / 32768;
    endfunction

    function automatic int slew(int w, int t);
        if (t > w + STP) return w + STP;
        if (t + STP < w) return w - STP;
        return t;
    endfunction

    // Applies the frame-end update with the inputs that are live at that edge.
    task automatic advance_model();
        if (bus.pausar_lectura !== 1'b1) begin
            mg = slew(mg, tgt(int'(bus.gripper)));
            mb = slew(mb, tgt(int'(bus.base)));
        end
    endtask

    // Counts high cycles per channel up to and including the next frame strobe.
    task automatic measure_frame(output int hg, output int hb, output int cyc);
        hg = 0; hb = 0; cyc = 0;
        for (int i = 0; i < F + 16; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.pwm_gripper === 1'b1) hg++;
            if (bus.pwm_base === 1'b1) hb++;
            if (bus.frame === 1'b1) return;
        end
    endtask

    task automatic test_reset();
        int hg, hb, cyc;
        exp_t e;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.pwm_gripper !== 1'b0) begin fails++; $display("FAIL reset_pwm_gripper: got %b want 0", bus.pwm_gripper); end
        tests++; if (bus.pwm_base !== 1'b0) begin fails++; $display("FAIL reset_pwm_base: got %b want 0", bus.pwm_base); end
        tests++; if (bus.frame !== 1'b0) begin fails++; $display("FAIL reset_frame: got %b want 0", bus.frame); end
        rst = 1'b0;
        mg = CTR; mb = CTR;
        for (int k = 0; k < 2; k++) begin
            q.push_back('{mg, mb});
            measure_frame(hg, hb, cyc);
            e = q.pop_front();
            tests++; if (cyc !== F) begin fails++; $display("FAIL reset_period[%0d]: got %0d want %0d", k, cyc, F); end
            tests++; if (hg !== e.g) begin fails++; $display("FAIL reset_width_gripper[%0d]: got %0d want %0d", k, hg, e.g); end
            tests++; if (hb !== e.b) begin fails++; $display("FAIL reset_width_base[%0d]: got %0d want %0d", k, hb, e.b); end
            advance_model();
        end
    endtask

    task automatic test_gripper_full();
        int hg, hb, cyc;
        exp_t e;
        @(posedge clk); #1;
        bus.gripper = 15'd32767;
        for (int k = 0; k < 11; k++) begin
            q.push_back('{mg, mb});
            measure_frame(hg, hb, cyc);
            e = q.pop_front();
            tests++; if (cyc !== F) begin fails++; $display("FAIL gfull_period[%0d]: got %0d want %0d", k, cyc, F); end
            tests++; if (hg !== e.g) begin fails++; $display("FAIL gfull_width_gripper[%0d]: got %0d want %0d", k, hg, e.g); end
            tests++; if (hb !== e.b) begin fails++; $display("FAIL gfull_width_base[%0d]: got %0d want %0d", k, hb, e.b); end
            advance_model();
        end
    endtask

    task automatic test_base_zero();
        int hg, hb, cyc;
        exp_t e;
        @(posedge clk); #1;
        bus.base = 15'd0;
        for (int k = 0; k < 11; k++) begin
            q.push_back('{mg, mb});
            measure_frame(hg, hb, cyc);
            e = q.pop_front();
            tests++; if (hg !== e.g) begin fails++; $display("FAIL bzero_width_gripper[%0d]: got %0d want %0d", k, hg, e.g); end
            tests++; if (hb !== e.b) begin fails++; $display("FAIL bzero_width_base[%0d]: got %0d want %0d", k, hb, e.b); end
            tests++; if (hb < MINP) begin fails++; $display("FAIL bzero_floor[%0d]: got %0d want >= %0d", k, hb, MINP); end
            advance_model();
        end
    endtask

    task automatic test_rst_midramp();
        int hg, hb, cyc;
        exp_t e;
        @(posedge clk); #1;
        bus.gripper = 15'd0;
        q.push_back('{mg, mb});
        measure_frame(hg, hb, cyc);
        e = q.pop_front();
        tests++; if (hg !== e.g) begin fails++; $display("FAIL rst_pre_width_gripper: got %0d want %0d", hg, e.g); end
        advance_model();
        // Land mid-pulse: the gripper width is far above this count.
        repeat (640) @(posedge clk);
        #1;
        tests++; if (bus.pwm_gripper !== 1'b1) begin fails++; $display("FAIL rst_pre_pulse: got %b want 1", bus.pwm_gripper); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.pwm_gripper !== 1'b0) begin fails++; $display("FAIL rst_mid_pwm_gripper: got %b want 0", bus.pwm_gripper); end
        tests++; if (bus.pwm_base !== 1'b0) begin fails++; $display("FAIL rst_mid_pwm_base: got %b want 0", bus.pwm_base); end
        tests++; if (bus.frame !== 1'b0) begin fails++; $display("FAIL rst_mid_frame: got %b want 0", bus.frame); end
        rst = 1'b0;
        mg = CTR; mb = CTR;
        for (int k = 0; k < 2; k++) begin
            q.push_back('{mg, mb});
            measure_frame(hg, hb, cyc);
            e = q.pop_front();
            tests++; if (cyc !== F) begin fails++; $display("FAIL rst_period[%0d]: got %0d want %0d", k, cyc, F); end
            tests++; if (hg !== e.g) begin fails++; $display("FAIL rst_width_gripper[%0d]: got %0d want %0d", k, hg, e.g); end
            tests++; if (hb !== e.b) begin fails++; $display("FAIL rst_width_base[%0d]: got %0d want %0d", k, hb, e.b); end
            advance_model();
        end
    endtask

    task automatic test_midframe();
        int hg, hb, cyc;
        exp_t e;
        @(posedge clk); #1;
        bus.gripper = 15'd16384;
        bus.base    = 15'd16384;
        for (int k = 0; k < 4 && mb != CTR; k++) begin
            q.push_back('{mg, mb});
            measure_frame(hg, hb, cyc);
            e = q.pop_front();
            tests++; if (hb !== e.b) begin fails++; $display("FAIL mid_settle_base[%0d]: got %0d want %0d", k, hb, e.b); end
            advance_model();
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                fork
                    begin
                        repeat (800) @(posedge clk);
                        #1;
                        bus.base = 15'd16500;
                    end
                join_none
            end
            q.push_back('{mg, mb});
            measure_frame(hg, hb, cyc);
            e = q.pop_front();
            tests++; if (hg !== e.g) begin fails++; $display("FAIL mid_width_gripper[%0d]: got %0d want %0d", k, hg, e.g); end
            tests++; if (hb !== e.b) begin fails++; $display("FAIL mid_width_base[%0d]: got %0d want %0d", k, hb, e.b); end
            advance_model();
        end
    endtask

    task automatic test_pause();
        int hg, hb, cyc;
        exp_t e;
        @(posedge clk); #1;
        bus.gripper = 15'd0;
        for (int k = 0; k < 7; k++) begin
            // Pause edges are placed just after a frame-end edge so the model sees them as the DUT does.
            if (k == 2) begin @(posedge clk); #1; bus.pausar_lectura = 1'b1; end
            if (k == 5) begin @(posedge clk); #1; bus.pausar_lectura = 1'b0; end
            q.push_back('{mg, mb});
            measure_frame(hg, hb, cyc);
            e = q.pop_front();
            tests++; if (hg !== e.g) begin fails++; $display("FAIL pause_width_gripper[%0d]: got %0d want %0d", k, hg, e.g); end
            tests++; if (hb !== e.b) begin fails++; $display("FAIL pause_width_base[%0d]: got %0d want %0d", k, hb, e.b); end
            advance_model();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.gripper        = 15'd16384;
        bus.base           = 15'd16384;
        bus.pausar_lectura = 1'b0;
        test_reset();
        test_gripper_full();
        test_base_zero();
        test_rst_midramp();
        test_midframe();
        test_pause();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
